// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults for the single-clock FIFO.
//   DATA_WIDTH_DEF - default stored word width
//   DEPTH_DEF      - default number of entries (power of two, >= 2)
//   ADDR_WIDTH_DEF - memory address width derived from DEPTH_DEF
//   ptr_t          - read/write pointer type: address bits plus one wrap bit
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 256;
  localparam int ADDR_WIDTH_DEF = $clog2(DEPTH_DEF);

  typedef logic [ADDR_WIDTH_DEF:0] ptr_t;

endpackage

// File: rtl/asynchronous_fifo_if.sv
// asynchronous_fifo_if: handshake and data bundle between a producer/consumer
// and the FIFO.
//   master modport - drives w_en, r_en, data_in; observes data_out and flags
//   slave modport  - the FIFO side: the reverse directions
interface asynchronous_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  w_en;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  write_error;
  logic                  read_error;

  modport master (
    output w_en, r_en, data_in,
    input  data_out, full, empty, write_error, read_error
  );

  modport slave (
    input  w_en, r_en, data_in,
    output data_out, full, empty, write_error, read_error
  );

endinterface

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage for the FIFO.
//   clk     - single clock for both ports
//   rst_n   - async active-low reset; clears only the read data register
//   i_we    - write strobe, i_wdata stored at i_waddr on the rising edge
//   i_re    - read strobe, o_rdata loads mem[i_raddr] on the rising edge
//   o_rdata - registered read data, holds between reads
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_we,
  input  logic [$clog2(DEPTH)-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0]         i_wdata,
  input  logic                          i_re,
  input  logic [$clog2(DEPTH)-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0]         o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage array: no reset, contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read data register: cleared by reset, otherwise holds until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= {DATA_WIDTH{1'b0}};
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/asynchronous_fifo.sv
// asynchronous_fifo: single-clock FIFO with full/empty flags and registered
// overflow/underflow error flags.
//   wclk   - the only clock, write and read sides both run on it
//   wrst_n - async active-low reset, clears pointers, data_out and flags
//   fifo   - slave side of asynchronous_fifo_if (w_en, r_en, data_in in;
//            data_out, full, empty, write_error, read_error out)
module asynchronous_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic               wclk,
  input  logic               wrst_n,
  asynchronous_fifo_if.slave fifo
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);

  // One extra MSB per pointer distinguishes full from empty when the
  // address bits coincide.
  logic [ADDR_WIDTH:0] r_wptr;
  logic [ADDR_WIDTH:0] r_rptr;
  logic                r_write_error;
  logic                r_read_error;
  logic                w_full;
  logic                w_empty;
  logic                w_wr_ok;
  logic                w_rd_ok;

  // Flags and accepted-access strobes, derived from the registered pointers.
  always_comb begin
    w_empty = (r_wptr == r_rptr);
    w_full  = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
              (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);
    // A read while full still proceeds; a write while full does not, even
    // though the read frees a slot on the same edge.
    w_wr_ok = fifo.w_en & ~w_full;
    w_rd_ok = fifo.r_en & ~w_empty;
  end

  // Write pointer: advances on every accepted write, wraps naturally.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wptr <= {(ADDR_WIDTH+1){1'b0}};
    end else if (w_wr_ok) begin
      r_wptr <= r_wptr + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end else begin
      r_wptr <= r_wptr;
    end
  end

  // Read pointer: advances on every accepted read, wraps naturally.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_rptr <= {(ADDR_WIDTH+1){1'b0}};
    end else if (w_rd_ok) begin
      r_rptr <= r_rptr + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end else begin
      r_rptr <= r_rptr;
    end
  end

  // Error flags: non-sticky, reflect only the attempt on the previous edge.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_write_error <= 1'b0;
      r_read_error  <= 1'b0;
    end else begin
      r_write_error <= fifo.w_en & w_full;
      r_read_error  <= fifo.r_en & w_empty;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (wclk),
    .rst_n   (wrst_n),
    .i_we    (w_wr_ok),
    .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
    .i_wdata (fifo.data_in),
    .i_re    (w_rd_ok),
    .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
    .o_rdata (fifo.data_out)
  );

  assign fifo.full        = w_full;
  assign fifo.empty       = w_empty;
  assign fifo.write_error = r_write_error;
  assign fifo.read_error  = r_read_error;

endmodule

// File: tb/tb_asynchronous_fifo.sv
// tb_asynchronous_fifo: directed stimulus with a queue-based scoreboard.
// The driver keeps a reference FIFO, checks flags each cycle and pushes the
// expected read word; a separate monitor pops and compares data_out whenever
// the DUT has performed a read.
module tb_asynchronous_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 256;

  logic wclk;
  logic wrst_n;

  asynchronous_fifo_if #(.DATA_WIDTH(DW)) ifc ();

  asynchronous_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .fifo   (ifc.slave)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_mon = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_q   [$];
  logic [DW-1:0] last_exp;
  logic          rd_seen;
  int            n_acc_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] v;
    v = i * 37 + 5;
    return v[DW-1:0];
  endfunction

  // DUT performed a read on this edge (sampled before the edge takes effect).
  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) rd_seen <= 1'b0;
    else         rd_seen <= ifc.r_en && !ifc.empty;
  end

  // Monitor: compare data_out with the scoreboard after every DUT read.
  always @(negedge wclk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_unexpected: got %0h expected no read at %0t", ifc.data_out, $time);
      end else begin
        chk("rd_data", 32'(ifc.data_out), 32'(exp_q.pop_front()));
        n_mon++;
      end
    end
  end

  // One clock: called at a negedge, drives inputs, predicts, checks at next negedge.
  task automatic cycle(input logic we, input logic re, input logic [DW-1:0] d);
    logic wok, rok, werr, rerr;
    int   cnt;
    ifc.w_en    = we;
    ifc.r_en    = re;
    ifc.data_in = d;
    cnt  = model_q.size();
    rok  = re && (cnt != 0);
    wok  = we && (cnt < DEPTH);
    werr = we && (cnt == DEPTH);
    rerr = re && (cnt == 0);
    if (rok) begin
      last_exp = model_q.pop_front();
      exp_q.push_back(last_exp);
    end
    if (wok) begin
      model_q.push_back(d);
      n_acc_w++;
    end
    @(posedge wclk);
    @(negedge wclk);
    cnt = model_q.size();
    chk("full",        32'(ifc.full),        32'(cnt == DEPTH));
    chk("empty",       32'(ifc.empty),       32'(cnt == 0));
    chk("write_error", 32'(ifc.write_error), 32'(werr));
    chk("read_error",  32'(ifc.read_error),  32'(rerr));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mon0;
    n_acc_w     = 0;
    last_exp    = '0;
    wrst_n      = 1'b0;
    ifc.w_en    = 1'b0;
    ifc.r_en    = 1'b0;
    ifc.data_in = '0;

    // Reset held for 10 clocks.
    repeat (10) @(negedge wclk);
    chk("rst_empty", 32'(ifc.empty),       32'd1);
    chk("rst_full",  32'(ifc.full),        32'd0);
    chk("rst_dout",  32'(ifc.data_out),    32'd0);
    chk("rst_werr",  32'(ifc.write_error), 32'd0);
    chk("rst_rerr",  32'(ifc.read_error),  32'd0);
    wrst_n = 1'b1;
    @(negedge wclk);

    // Fill with 256 words, then drain reading 1 of every 3 cycles.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, pat(i));
    chk("fill_full", 32'(ifc.full), 32'd1);
    for (int i = 0; i < 3 * DEPTH; i++) cycle(1'b0, (i % 3) == 0, 8'h00);
    chk("drain_empty", 32'(ifc.empty), 32'd1);

    // Overflow: 257 writes then 4 more attempts.
    for (int i = 0; i < DEPTH + 5; i++) cycle(1'b1, 1'b0, pat(i + 1000));
    chk("ovf_werr", 32'(ifc.write_error), 32'd1);

    // Drain 256 then underflow with a 257th read; data_out must hold word 256.
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b1, 8'h00);
    chk("udf_dout_hold", 32'(ifc.data_out), 32'(pat(DEPTH - 1 + 1000)));
    cycle(1'b0, 1'b0, 8'h00);
    chk("udf_rerr_clear", 32'(ifc.read_error), 32'd0);

    // Concurrent: 512 write attempts with 1-in-3 reads.
    n_acc_w = 0;
    mon0    = n_mon;
    for (int i = 0; i < 2 * DEPTH; i++) cycle(1'b1, (i % 3) == 0, pat(i + 3000));
    cycle(1'b0, 1'b0, 8'h00);
    chk("conc_balance", 32'(n_acc_w), 32'((n_mon - mon0) + model_q.size()));
    while (model_q.size() != 0) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    // Mid-operation reset with 100 words stored (one read leaves data_out nonzero).
    for (int i = 0; i < 101; i++) cycle(1'b1, 1'b0, pat(i + 7000));
    cycle(1'b0, 1'b1, 8'h00);
    ifc.w_en = 1'b0;
    ifc.r_en = 1'b0;
    @(posedge wclk);
    #2;
    wrst_n = 1'b0;
    #1;
    chk("mrst_empty", 32'(ifc.empty),       32'd1);
    chk("mrst_full",  32'(ifc.full),        32'd0);
    chk("mrst_dout",  32'(ifc.data_out),    32'd0);
    chk("mrst_werr",  32'(ifc.write_error), 32'd0);
    chk("mrst_rerr",  32'(ifc.read_error),  32'd0);
    model_q.delete();
    @(negedge wclk);
    wrst_n = 1'b1;
    cycle(1'b0, 1'b1, 8'h00);
    chk("mrst_read_err", 32'(ifc.read_error), 32'd1);
    cycle(1'b0, 1'b0, 8'h00);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
